// File: rtl/vx_commit_merge.sv
// vx_commit_merge: merges partial-lane ALU beats into one full-warp writeback packet.
// Define COMMIT_MERGE_CHECK_EN to build in the sticky protocol checker driving proto_err.
module vx_commit_merge #(
  parameter  int NUM_LANES   = 2,
  parameter  int NUM_THREADS = 4,
  parameter  int XLEN        = 32,
  parameter  int UUID_W      = 44,
  parameter  int NW_W        = 2,
  parameter  int PC_W        = 30,
  parameter  int NR_W        = 6,
  localparam int PCNT        = NUM_THREADS / NUM_LANES,
  localparam int PID_W       = (PCNT > 1) ? $clog2(PCNT) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_W-1:0]           in_uuid,
  input  logic [NW_W-1:0]             in_wid,
  input  logic [PC_W-1:0]             in_PC,
  input  logic [NR_W-1:0]             in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_W-1:0]            in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_W-1:0]           out_uuid,
  output logic [NW_W-1:0]             out_wid,
  output logic [PC_W-1:0]             out_PC,
  output logic [NR_W-1:0]             out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        proto_err
);
  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;
  state_t state;
  logic acc, new_pkt;
  logic [NUM_THREADS-1:0]      tmask_n;
  logic [NUM_THREADS*XLEN-1:0] data_n;
  assign in_ready  = (state != FULL) || out_ready;
  assign out_valid = (state == FULL);
  assign acc       = in_valid && in_ready;
  assign new_pkt   = in_sop || (state != ACCUM);
  // out-of-range pids match no slice, so only the eop takes effect
  always_comb begin
    tmask_n = new_pkt ? '0 : out_tmask;
    data_n  = new_pkt ? '0 : out_data;
    for (int p = 0; p < PCNT; p++) begin
      if (in_pid == PID_W'(p)) begin
        tmask_n[p*NUM_LANES +: NUM_LANES] = in_tmask;
        for (int l = 0; l < NUM_LANES; l++)
          data_n[(p*NUM_LANES+l)*XLEN +: XLEN] = in_tmask[l] ? in_data[l*XLEN +: XLEN] : '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_uuid  <= '0;
      out_wid   <= '0;
      out_PC    <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
      out_tmask <= '0;
      out_data  <= '0;
    end else if (acc) begin
      state     <= in_eop ? FULL : ACCUM;
      out_tmask <= tmask_n;
      out_data  <= data_n;
      if (new_pkt) begin
        out_uuid <= in_uuid;
        out_wid  <= in_wid;
        out_PC   <= in_PC;
        out_rd   <= in_rd;
        out_wb   <= in_wb;
      end
    end else if (state == FULL && out_ready) begin
      state <= IDLE;
    end
  end
`ifdef COMMIT_MERGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (acc && ((state == IDLE && !in_sop) || (state == ACCUM && in_sop) ||
                     (!in_sop && state != IDLE && in_wid != out_wid)))
      err_q <= 1'b1;
  end
  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_vx_commit_merge.sv
// tb_vx_commit_merge: table-driven and directed checks of the commit merge block.
module tb_vx_commit_merge;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_ready, in_wb = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [43:0] in_uuid = '0, out_uuid;
  logic [1:0]  in_wid = '0, out_wid, in_tmask = '0;
  logic [29:0] in_PC = '0, out_PC;
  logic [5:0]  in_rd = '0, out_rd;
  logic [63:0] in_data = '0;
  logic [0:0]  in_pid = '0;
  logic out_valid, out_ready = 1'b0, out_wb, proto_err;
  logic [3:0]   out_tmask;
  logic [127:0] out_data;
  int compared = 0, mismatched = 0;
`ifdef COMMIT_MERGE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  vx_commit_merge dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_PC(out_PC), .out_rd(out_rd), .out_wb(out_wb), .out_tmask(out_tmask),
    .out_data(out_data), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, sop, eop, ordy;
    logic [0:0] pid;
    logic [1:0] tm;
    logic [63:0] d;
    logic [1:0] wid;
    logic ev, eir;
    logic [3:0] etm;
    logic [127:0] ed;
    logic [1:0] ewid;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [0:0] pid,
                       input logic [1:0] tm, input logic [63:0] d, input logic [1:0] wid);
    in_valid = v; in_sop = sop; in_eop = eop; in_pid = pid; in_tmask = tm; in_data = d;
    in_wid = wid; in_uuid = {42'd0, wid}; in_PC = {28'd0, wid}; in_rd = {4'd0, wid}; in_wb = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string n, input logic [3:0] tm, input logic [127:0] d, input logic [1:0] wid);
    chk({n, "_valid"}, out_valid, 1'b1);
    chk({n, "_tmask"}, out_tmask, tm);
    chk({n, "_data"}, out_data, d);
    chk({n, "_wid"}, out_wid, wid);
    chk({n, "_uuid"}, out_uuid, {42'd0, wid});
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, {32'hB, 32'hA}, 2'd1, 1'b0, 1'b1, 4'h0, 128'd0, 2'd0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, {32'hD, 32'hC}, 2'd2, 1'b1, 1'b0, 4'hF,
              {32'hD, 32'hC, 32'hB, 32'hA}, 2'd1};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, {32'hE, 32'hE}, 2'd3, 1'b1, 1'b0, 4'hF,
              {32'hD, 32'hC, 32'hB, 32'hA}, 2'd1};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'd0, 2'd0, 1'b0, 1'b1, 4'h0, 128'd0, 2'd0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, {32'hDEAD, 32'h7}, 2'd3, 1'b1, 1'b0, 4'h4,
              {32'h0, 32'h7, 32'h0, 32'h0}, 2'd3};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, {32'h5, 32'h6}, 2'd0, 1'b1, 1'b1, 4'h2,
              {32'h0, 32'h0, 32'h5, 32'h0}, 2'd0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'd0, 2'd0, 1'b0, 1'b1, 4'h0, 128'd0, 2'd0};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, {32'h9, 32'h8}, 2'd2, 1'b1, 1'b0, 4'hC,
              {32'h9, 32'h8, 32'h0, 32'h0}, 2'd2};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'd0, 2'd0, 1'b0, 1'b1, 4'h0, 128'd0, 2'd0};

    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_tmask", out_tmask, 4'h0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_uuid", out_uuid, 44'd0);
    chk("rst_err", proto_err, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    step();

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v, vt[i].sop, vt[i].eop, vt[i].pid, vt[i].tm, vt[i].d, vt[i].wid);
      out_ready = vt[i].ordy;
      step();
      chk($sformatf("row%0d_valid", i), out_valid, vt[i].ev);
      chk($sformatf("row%0d_in_ready", i), in_ready, vt[i].eir);
      if (vt[i].ev) begin
        chk($sformatf("row%0d_tmask", i), out_tmask, vt[i].etm);
        chk($sformatf("row%0d_data", i), out_data, vt[i].ed);
        chk($sformatf("row%0d_wid", i), out_wid, vt[i].ewid);
        chk($sformatf("row%0d_uuid", i), out_uuid, {42'd0, vt[i].ewid});
      end
    end

    // backpressure hold, then drain and accept on the same edge
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, {32'h22, 32'h11}, 2'd1);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, {32'h44, 32'h33}, 2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_pkt($sformatf("hold%0d", i), 4'h3, {64'd0, 32'h22, 32'h11}, 2'd1);
      chk($sformatf("hold%0d_in_ready", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", in_ready, 1'b1);
    step();
    chk_pkt("b2b", 4'hC, {32'h44, 32'h33, 64'd0}, 2'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 2'd0);
    step();
    chk("b2b_idle", out_valid, 1'b0);

    // asynchronous reset mid-packet discards it
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, {32'hAA, 32'hBB}, 2'd3);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 2'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_tmask", out_tmask, 4'h0);
    #2 reset = 1'b1;
    step();
    step();
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, {32'h66, 32'h55}, 2'd1);
    step();
    chk_pkt("post_rst_pkt", 4'hC, {32'h66, 32'h55, 64'd0}, 2'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 2'd0);
    step();

    // wid change inside a packet; datapath result is build-independent
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("err_clear", proto_err, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, {32'hA1, 32'hA0}, 2'd1);
    step();
    chk("err_first_beat", proto_err, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, {32'hFF, 32'hC0}, 2'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 2'd0);
    chk_pkt("err_pkt", 4'h7, {32'h0, 32'hC0, 32'hA1, 32'hA0}, 2'd1);
    chk("err_set", proto_err, ERR_EXP);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("err_sticky%0d", i), proto_err, ERR_EXP);
    end
    chk("err_end_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
